// File: rtl/itag_retire.sv
// rtl/itag_retire.sv - in-order itag retirement queue returning up to 8 itags per cycle
// Circular {tag, done} queue; retires consecutive done entries at head, or drains everything after a flush.
module itag_retire #(
  parameter int DEPTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alloc_en,
  input  logic [TAG_W-1:0] alloc_tag_0,
  input  logic [TAG_W-1:0] alloc_tag_1,
  input  logic [TAG_W-1:0] alloc_tag_2,
  input  logic [TAG_W-1:0] alloc_tag_3,
  output logic             alloc_ready,
  input  logic [3:0]       cmp_en,
  input  logic [TAG_W-1:0] cmp_tag_0,
  input  logic [TAG_W-1:0] cmp_tag_1,
  input  logic [TAG_W-1:0] cmp_tag_2,
  input  logic [TAG_W-1:0] cmp_tag_3,
  input  logic             flush,
  output logic [7:0]       wb_itag_en,
  output logic [TAG_W-1:0] itag_0,
  output logic [TAG_W-1:0] itag_1,
  output logic [TAG_W-1:0] itag_2,
  output logic [TAG_W-1:0] itag_3,
  output logic [TAG_W-1:0] itag_4,
  output logic [TAG_W-1:0] itag_5,
  output logic [TAG_W-1:0] itag_6,
  output logic [TAG_W-1:0] itag_7,
  output logic             draining
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic {RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [TAG_W-1:0]  tag_q [DEPTH];
  logic [TAG_W-1:0]  tag_d [DEPTH];
  logic [DEPTH-1:0]  done_q, done_d;
  logic [7:0]        wb_en_q, wb_en_d;
  logic [TAG_W-1:0]  itag_q [8];
  logic [TAG_W-1:0]  itag_d [8];

  logic [TAG_W-1:0]  a_tag [4];
  logic [TAG_W-1:0]  c_tag [4];
  logic [PW-1:0]     occ;
  logic [PW-1:0]     remain;
  logic [PW:0]       occ_ext;
  logic [DEPTH-1:0]  valid;
  logic [IW-1:0]     off;
  logic [IW-1:0]     idx;
  logic [3:0]        k;
  logic [2:0]        pos;
  logic              stop;

  assign a_tag[0] = alloc_tag_0;
  assign a_tag[1] = alloc_tag_1;
  assign a_tag[2] = alloc_tag_2;
  assign a_tag[3] = alloc_tag_3;
  assign c_tag[0] = cmp_tag_0;
  assign c_tag[1] = cmp_tag_1;
  assign c_tag[2] = cmp_tag_2;
  assign c_tag[3] = cmp_tag_3;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign occ         = tail_q - head_q;
  assign occ_ext     = {1'b0, occ};
  assign alloc_ready = (state_q == RUN) && (occ_ext + (PW+1)'(4) <= (PW+1)'(DEPTH));

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = IW'(i) - head_q[IW-1:0];
      valid[i] = ({1'b0, off} < occ);
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    tag_d   = tag_q;
    done_d  = done_q;
    wb_en_d = '0;
    itag_d  = '{default: '0};
    k       = '0;
    pos     = '0;
    stop    = 1'b0;
    idx     = '0;

    // Retire window: consecutive done entries from head in RUN, any entries in DRAIN.
    for (int j = 0; j < 8; j++) begin
      idx = head_q[IW-1:0] + IW'(j);
      if (!stop && (PW'(j) < occ) && ((state_q == DRAIN) || done_q[idx])) begin
        wb_en_d[j] = 1'b1;
        itag_d[j]  = tag_q[idx];
        k          = k + 4'd1;
      end else begin
        stop = 1'b1;
      end
    end
    head_d = head_q + PW'(k);
    remain = occ - PW'(k);

    if (state_q == RUN) begin
      for (int p = 0; p < 4; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cmp_en[p] && valid[i] && (tag_q[i] == c_tag[p])) done_d[i] = 1'b1;
        end
      end
      if (flush) begin
        if (remain != '0) state_d = DRAIN;
      end else if (alloc_ready) begin
        // Allocation after completion so a same-cycle completion cannot mark a new entry.
        for (int l = 0; l < 4; l++) begin
          if (alloc_en[l]) begin
            idx         = tail_q[IW-1:0] + IW'(pos);
            tag_d[idx]  = a_tag[l];
            done_d[idx] = 1'b0;
            pos         = pos + 3'd1;
          end
        end
        tail_d = tail_q + PW'(pos);
      end
    end else if (remain == '0) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      tag_q   <= '{default: '0};
      done_q  <= '0;
      wb_en_q <= '0;
      itag_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      tag_q   <= tag_d;
      done_q  <= done_d;
      wb_en_q <= wb_en_d;
      itag_q  <= itag_d;
    end
  end

  assign wb_itag_en = wb_en_q;
  assign itag_0     = itag_q[0];
  assign itag_1     = itag_q[1];
  assign itag_2     = itag_q[2];
  assign itag_3     = itag_q[3];
  assign itag_4     = itag_q[4];
  assign itag_5     = itag_q[5];
  assign itag_6     = itag_q[6];
  assign itag_7     = itag_q[7];
  assign draining   = (state_q == DRAIN);

endmodule

// File: doc/itag_retire.md
ITAG_RETIRE -- requirements
Module: itag_retire

Interface
REQ-001 Parameters SHALL be: DEPTH, 32, in-flight entry count; TAG_W, 5, itag width.
REQ-002 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 alloc_en  input  4  dispatch lanes carrying newly tagged instructions, thermometer-coded from bit 0.
REQ-006 alloc_tag_0..alloc_tag_3  input  TAG_W each  itag per dispatch lane, program order lane 0 first.
REQ-007 alloc_ready  output  1  queue can accept 4 allocations this cycle.
REQ-008 cmp_en  input  4  execution-completion valid per writeback port.
REQ-009 cmp_tag_0..cmp_tag_3  input  TAG_W each  itag of completing instruction.
REQ-010 flush  input  1  pipeline flush; discard all in-flight entries.
REQ-011 wb_itag_en  output  8  return strobes to itag free list, thermometer-coded from bit 0.
REQ-012 itag_0..itag_7  output  TAG_W each  returned itags, oldest on itag_0; zero when corresponding strobe low.
REQ-013 draining  output  1  high while flush drain in progress.

Function
REQ-014 Storage SHALL be a circular queue of DEPTH entries {tag, done}, head/tail pointers of log2(DEPTH)+1 bits, occupancy = tail - head modulo 2*DEPTH.
REQ-015 alloc_ready SHALL be combinational: high iff state RUN and occupancy + 4 <= DEPTH.
REQ-016 When alloc_ready and alloc_en != 0, entries SHALL be written at tail, tail+1, ... with done=0, and tail SHALL advance by popcount(alloc_en) at the edge.
REQ-017 alloc_en while alloc_ready low SHALL be ignored with no state change.
REQ-018 Each cmp_en port SHALL set done on the valid entry whose tag equals cmp_tag at the edge; no match SHALL be ignored; duplicate tags across ports SHALL be harmless.
REQ-019 Completion for an entry allocated in the same cycle SHALL be ignored.
REQ-020 In RUN, retire count k SHALL be the number of consecutive done entries starting at head, capped at 8 and at occupancy.
REQ-021 Retirement SHALL be registered: k and tags evaluated from state at cycle N appear on wb_itag_en/itag_x in cycle N+1; head advances by k at the same edge.
REQ-022 Minimum completion-to-return latency SHALL be 2 cycles (done set at edge E, outputs valid after edge E+1).
REQ-023 Pointer arithmetic SHALL wrap modulo DEPTH for indexing; retirement windows crossing index DEPTH-1 -> 0 SHALL be handled.
REQ-024 FSM states SHALL be RUN and DRAIN; RUN -> DRAIN on flush; DRAIN -> RUN when occupancy reaches 0 after a drain step.
REQ-025 On flush in RUN with occupancy 0, state SHALL stay RUN and no strobes SHALL assert.
REQ-026 In DRAIN, up to 8 oldest entries per cycle SHALL be returned regardless of done; completions and allocations ignored; flush ignored.
REQ-027 Flush in the same cycle as alloc_en SHALL drop the allocation; flush same cycle as retirement evaluation SHALL still return that cycle's k done entries, remaining entries drained.
REQ-028 draining SHALL equal (state == DRAIN), registered.
REQ-029 wb_itag_en SHALL never exceed occupancy and never return a tag twice.

Reset
REQ-030 On rst: head=tail=0, all done=0, state RUN, wb_itag_en=0, itag_0..7=0, draining=0; alloc_ready=1 from the first cycle after reset.
REQ-031 rst mid-drain or mid-retire SHALL abandon all entries with no further strobes.

Verification
REQ-032 Alloc tags 3,4,5,6; complete 4,5 then 3 -> one cycle wb_itag_en=0b0000_0111, itag_0..2=3,4,5; tag 6 held.
REQ-033 Fill 32 entries (8 cycles x 4) -> alloc_ready=0 at occupancy 29+; complete all -> four cycles of 0xFF returning tags in alloc order.
REQ-034 Head at index 28, 8 done entries -> wb_itag_en=0xFF, tags from indices 28..31,0..3 in order.
REQ-035 20 entries in flight, none done, flush -> draining=1, returns 8,8,4 over 3 cycles, then RUN, alloc_ready=1.
REQ-036 Completion with unknown tag and completion same cycle as its alloc -> no done set, no strobe.
REQ-037 Assert rst while draining with 16 entries left -> next cycle all outputs 0, state RUN, occupancy 0.
